// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake and hands instructions to decode through a registered output
// backed by a one-entry skid buffer. Redirects squash wrong-path fetches.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   input  logic        stall,
   input  logic        branchEn,
   input  logic [31:0] branchTarget,
   output logic        instValid,
   output logic [31:0] inst,
   output logic [31:0] instPc,
   output logic [31:0] pcPlus4,
   output logic        misalignErr
);

   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] req_addr_nxt;
   logic        req_nxt;
   logic        out_valid_nxt;
   logic [31:0] out_inst_nxt, out_pc_nxt;
   logic        skid_valid, skid_valid_nxt;
   logic [31:0] skid_inst, skid_inst_nxt;
   logic [31:0] skid_pc, skid_pc_nxt;
   logic        squash, squash_nxt;
   logic        misalign_nxt;
   logic        out_free_c;

   // Output register can take a new word when empty or being consumed now
   assign out_free_c = !instValid || !stall;

   // Next-state, fetch sequencing, delivery and redirect handling
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      req_addr_nxt   = imemAddr;
      out_valid_nxt  = instValid;
      out_inst_nxt   = inst;
      out_pc_nxt     = instPc;
      skid_valid_nxt = skid_valid;
      skid_inst_nxt  = skid_inst;
      skid_pc_nxt    = skid_pc;
      squash_nxt     = squash;
      misalign_nxt   = 1'b0;

      if (branchEn) begin
         // Redirect wins over everything; any same-cycle ack data is dropped
         pc_nxt         = {branchTarget[31:2], 2'b00};
         out_valid_nxt  = 1'b0;
         out_inst_nxt   = NOP_INST;
         skid_valid_nxt = 1'b0;
         misalign_nxt   = (branchTarget[1:0] != 2'b00);
         if (imemReq && !imemAck) begin
            squash_nxt = 1'b1;
            state_nxt  = DRAIN;
         end else begin
            squash_nxt   = 1'b0;
            state_nxt    = REQ;
            req_addr_nxt = {branchTarget[31:2], 2'b00};
         end
      end else begin
         if (out_free_c) begin
            if (skid_valid) begin
               out_valid_nxt  = 1'b1;
               out_inst_nxt   = skid_inst;
               out_pc_nxt     = skid_pc;
               skid_valid_nxt = 1'b0;
            end else begin
               out_valid_nxt = 1'b0;
               out_inst_nxt  = NOP_INST;
            end
         end

         case (state)
            IDLE: begin
               state_nxt    = REQ;
               req_addr_nxt = pc;
            end
            REQ: begin
               if (imemAck && !squash) begin
                  pc_nxt = pc + PC_STEP;
                  if (out_free_c && !skid_valid) begin
                     out_valid_nxt = 1'b1;
                     out_inst_nxt  = imemData;
                     out_pc_nxt    = imemAddr;
                     state_nxt     = REQ;
                     req_addr_nxt  = pc + PC_STEP;
                  end else begin
                     skid_valid_nxt = 1'b1;
                     skid_inst_nxt  = imemData;
                     skid_pc_nxt    = imemAddr;
                     state_nxt      = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!skid_valid || out_free_c) begin
                  state_nxt    = REQ;
                  req_addr_nxt = pc;
               end
            end
            DRAIN: begin
               if (imemAck) begin
                  squash_nxt   = 1'b0;
                  state_nxt    = REQ;
                  req_addr_nxt = pc;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      req_nxt    = (state_nxt == REQ) || (state_nxt == DRAIN);
      out_pc_nxt = out_pc_nxt;
   end

   // State, PC, request and buffer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         imemAddr    <= RESET_PC;
         imemReq     <= 1'b0;
         instValid   <= 1'b0;
         inst        <= NOP_INST;
         instPc      <= 32'h0000_0000;
         pcPlus4     <= 32'h0000_0004;
         skid_valid  <= 1'b0;
         skid_inst   <= NOP_INST;
         skid_pc     <= 32'h0000_0000;
         squash      <= 1'b0;
         misalignErr <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         imemAddr    <= req_addr_nxt;
         imemReq     <= req_nxt;
         instValid   <= out_valid_nxt;
         inst        <= out_inst_nxt;
         instPc      <= out_pc_nxt;
         pcPlus4     <= out_pc_nxt + PC_STEP;
         skid_valid  <= skid_valid_nxt;
         skid_inst   <= skid_inst_nxt;
         skid_pc     <= skid_pc_nxt;
         squash      <= squash_nxt;
         misalignErr <= misalign_nxt;
      end
   end

endmodule
